// File: rtl/melody_sequencer_if.sv
// Host and tone-generator signal bundle for melody_sequencer.
// The loop input exists only when MELODY_SEQ_LOOP_EN is defined.
interface melody_sequencer_if #(
    parameter int ADDR_W = 6
);
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [11:0]       wr_data;
    logic              start;
    logic              stop;
    logic              busy;
    logic              tone_en;
    logic [3:0]        note;
    logic [2:0]        octave;
    logic [ADDR_W-1:0] play_addr;
    logic              song_done;
`ifdef MELODY_SEQ_LOOP_EN
    logic              loop;

    modport master (
        output wr_en, wr_addr, wr_data, start, stop, loop,
        input  busy, tone_en, note, octave, play_addr, song_done
    );
    modport slave (
        input  wr_en, wr_addr, wr_data, start, stop, loop,
        output busy, tone_en, note, octave, play_addr, song_done
    );
`else
    modport master (
        output wr_en, wr_addr, wr_data, start, stop,
        input  busy, tone_en, note, octave, play_addr, song_done
    );
    modport slave (
        input  wr_en, wr_addr, wr_data, start, stop,
        output busy, tone_en, note, octave, play_addr, song_done
    );
`endif
endinterface

// File: rtl/melody_sequencer.sv
// Walks a writable note memory and drives the square-wave tone generator.
// Define MELODY_SEQ_LOOP_EN to add a loop input that replays the song until stopped.
module melody_sequencer #(
    parameter int ADDR_W      = 6,
    parameter int BEAT_CYCLES = 6250000,
    parameter int GAP_CYCLES  = 625000
) (
    input  logic              clk,
    input  logic              rst_n,
    melody_sequencer_if.slave bus
);
    localparam int                DEPTH     = 2 ** ADDR_W;
    localparam logic [31:0]       BEAT_LEN  = 32'(BEAT_CYCLES);
    localparam logic [31:0]       GAP_LEN   = 32'(GAP_CYCLES);
    localparam logic [ADDR_W-1:0] LAST_ADDR = {ADDR_W{1'b1}};

    typedef enum logic [2:0] {IDLE, FETCH, DECODE, PLAY, GAP, DONE} state_t;

    state_t            state, state_next;
    logic [ADDR_W-1:0] play_addr, addr_next;
    logic [3:0]        note_q, note_next;
    logic [2:0]        octave_q, octave_next;
    logic              rest_q, rest_next;
    logic [31:0]       counter, count_next;
    logic              tone_en_q, tone_next;

    logic [11:0]       mem [DEPTH];
    logic [11:0]       entry;
    logic [3:0]        e_note;
    logic [2:0]        e_oct;
    logic              e_rest;
    logic [3:0]        e_dur;

    assign e_note = entry[3:0];
    assign e_oct  = entry[6:4];
    assign e_rest = entry[7];
    assign e_dur  = entry[11:8];

    // The song can only be edited while idle; the read port runs every cycle.
    always_ff @(posedge clk) begin
        if (bus.wr_en && state == IDLE) begin
            mem[bus.wr_addr] <= bus.wr_data;
        end
        entry <= mem[play_addr];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            play_addr <= '0;
            note_q    <= '0;
            octave_q  <= '0;
            rest_q    <= 1'b0;
            counter   <= '0;
            tone_en_q <= 1'b0;
        end else begin
            state     <= state_next;
            play_addr <= addr_next;
            note_q    <= note_next;
            octave_q  <= octave_next;
            rest_q    <= rest_next;
            counter   <= count_next;
            tone_en_q <= tone_next;
        end
    end

    always_comb begin
        state_next  = state;
        addr_next   = play_addr;
        note_next   = note_q;
        octave_next = octave_q;
        rest_next   = rest_q;
        count_next  = counter;
        tone_next   = 1'b0;
        if (bus.stop && state != IDLE) begin
            state_next = IDLE;
        end else begin
            unique case (state)
                IDLE: begin
                    if (bus.start && !bus.stop) begin
                        state_next = FETCH;
                        addr_next  = '0;
                    end
                end
                FETCH: state_next = DECODE;
                DECODE: begin
                    if (e_note == 4'd15) begin
                        state_next = DONE;
                    end else begin
                        note_next   = e_note;
                        octave_next = (e_oct > 3'd5) ? 3'd5 : e_oct;
                        rest_next   = e_rest || (e_note >= 4'd12);
                        count_next  = ({28'd0, e_dur} + 32'd1) * BEAT_LEN - GAP_LEN;
                        state_next  = PLAY;
                    end
                end
                // tone_en is registered, so it trails PLAY by one cycle.
                PLAY: begin
                    tone_next = !rest_q;
                    if (counter == 32'd1) begin
                        count_next = GAP_LEN;
                        state_next = GAP;
                    end else begin
                        count_next = counter - 32'd1;
                    end
                end
                GAP: begin
                    if (counter == 32'd1) begin
                        if (play_addr == LAST_ADDR) begin
                            state_next = DONE;
                        end else begin
                            addr_next  = play_addr + ADDR_W'(1);
                            state_next = FETCH;
                        end
                    end else begin
                        count_next = counter - 32'd1;
                    end
                end
                DONE: begin
`ifdef MELODY_SEQ_LOOP_EN
                    if (bus.loop) begin
                        state_next = FETCH;
                        addr_next  = '0;
                    end else begin
                        state_next = IDLE;
                    end
`else
                    state_next = IDLE;
`endif
                end
                default: state_next = IDLE;
            endcase
        end
    end

    assign bus.busy      = (state != IDLE);
    assign bus.song_done = (state == DONE);
    assign bus.tone_en   = tone_en_q;
    assign bus.note      = note_q;
    assign bus.octave    = octave_q;
    assign bus.play_addr = play_addr;

endmodule

// File: tb/tb_melody_sequencer.sv
// Scoreboard bench for melody_sequencer: a song-level model predicts every tone
// burst and song summary, and a negedge monitor compares what the DUT produces.
module tb_melody_sequencer;
    localparam int ADDR_W = 2;
    localparam int DEPTH  = 2 ** ADDR_W;
    localparam int BEAT   = 8;
    localparam int GAP    = 2;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    melody_sequencer_if #(.ADDR_W(ADDR_W)) bus ();

    melody_sequencer #(
        .ADDR_W     (ADDR_W),
        .BEAT_CYCLES(BEAT),
        .GAP_CYCLES (GAP)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    typedef struct { int note; int octave; int offset; int len; } tone_t;
    typedef struct { int busy_len; int dones; int addr; int octave; } song_t;

    tone_t       tone_q[$];
    song_t       song_q[$];
    logic [11:0] mem_model [DEPTH];
    int          model_oct = 0;
    int          checks    = 0;
    int          passes    = 0;

    task automatic check_output(input string name, input int actual, input int expected);
        checks++;
        if (actual == expected) passes++;
        else $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    endtask

    function automatic logic [11:0] make_entry(input int note, input int oct, input bit rest, input int dur);
        logic [11:0] e;
        e[3:0]  = 4'(note);
        e[6:4]  = 3'(oct);
        e[7]    = rest;
        e[11:8] = 4'(dur);
        return e;
    endfunction

    // Song-level timing: each note slot is (dur+1)*BEAT+2 cycles, the end marker
    // costs FETCH+DECODE+DONE, running off the last address costs one DONE cycle.
    // Offsets count busy cycles from the first one (1-based).
    task automatic predict(input int stop_at, input bit loop_mode);
        int m, t, addr, n, oct, dur, play, slot;
        bit is_end, is_rest;
        logic [11:0] e;
        tone_t tr;
        song_t s;
        m = (stop_at > 0) ? stop_at : 32'h3fff_ffff;
        t = 0;
        addr = 0;
        s.dones = 0;
        s.busy_len = 0;
        s.addr = 0;
        forever begin
            e = mem_model[addr];
            n = int'(e[3:0]);
            oct = int'(e[6:4]);
            dur = int'(e[11:8]);
            is_end = (n == 15);
            is_rest = e[7] || (n >= 12);
            play = (dur + 1) * BEAT - GAP;
            slot = is_end ? 3 : play + GAP + 2;
            if (!is_end && t + 2 < m) model_oct = (oct > 5) ? 5 : oct;
            if (!is_end && !is_rest && t + 4 <= m) begin
                tr.note = n;
                tr.octave = (oct > 5) ? 5 : oct;
                tr.offset = t + 4;
                tr.len = (play < m - t - 3) ? play : m - t - 3;
                tone_q.push_back(tr);
            end
            if (is_end && t + 3 <= m) s.dones++;
            if (m <= t + slot) begin
                s.busy_len = m;
                s.addr = addr;
                break;
            end
            t += slot;
            if (!is_end && addr < DEPTH - 1) begin
                addr++;
            end else begin
                if (!is_end) begin
                    if (t + 1 <= m) s.dones++;
                    if (m <= t + 1) begin
                        s.busy_len = m;
                        s.addr = addr;
                        break;
                    end
                    t += 1;
                end
                if (loop_mode) begin
                    addr = 0;
                end else begin
                    s.busy_len = t;
                    s.addr = addr;
                    break;
                end
            end
        end
        s.octave = model_oct;
        song_q.push_back(s);
    endtask

    task automatic write_entry(input int addr, input logic [11:0] data);
        @(posedge clk);
        #1;
        bus.wr_en = 1'b1;
        bus.wr_addr = ADDR_W'(addr);
        bus.wr_data = data;
        @(posedge clk);
        #1;
        bus.wr_en = 1'b0;
        mem_model[addr] = data;
    endtask

    task automatic load_song(input logic [11:0] e0, input logic [11:0] e1,
                             input logic [11:0] e2, input logic [11:0] e3);
        write_entry(0, e0);
        write_entry(1, e1);
        write_entry(2, e2);
        write_entry(3, e3);
    endtask

    // poke: a write to entry 0 and a second start while busy, both to be ignored.
    task automatic apply_stimulus(input int stop_at, input bit loop_mode, input bit poke);
        bit finished;
        predict(stop_at, loop_mode);
        @(posedge clk);
        #1 bus.start = 1'b1;
        @(posedge clk);
        #1 bus.start = 1'b0;
        finished = 1'b0;
        for (int c = 1; c <= 2000; c++) begin
            bus.stop    = (stop_at > 0) && (c == stop_at);
            bus.wr_en   = poke && (c == 1);
            bus.wr_addr = '0;
            bus.wr_data = 12'h259;
            bus.start   = poke && (c == 2);
            @(posedge clk);
            #1;
            if (!bus.busy) begin
                finished = 1'b1;
                break;
            end
        end
        bus.stop  = 1'b0;
        bus.wr_en = 1'b0;
        bus.start = 1'b0;
        check_output("song_terminates", int'(finished), 1);
        repeat (2) @(posedge clk);
    endtask

    initial begin : monitor
        int busy_cnt, done_cnt, tone_start, tone_len, last_note, last_oct;
        bit prev_busy, prev_tone;
        tone_t tr;
        song_t s;
        busy_cnt = 0; done_cnt = 0; tone_start = 0; tone_len = 0;
        last_note = 0; last_oct = 0; prev_busy = 0; prev_tone = 0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                busy_cnt = 0;
                done_cnt = 0;
                prev_busy = 0;
                prev_tone = 0;
            end else begin
                if (bus.busy) busy_cnt++;
                if (bus.song_done) done_cnt++;
                if (bus.tone_en && !prev_tone) begin
                    tone_start = busy_cnt;
                    tone_len = 0;
                end
                if (bus.tone_en) begin
                    tone_len++;
                    last_note = int'(bus.note);
                    last_oct = int'(bus.octave);
                end
                if (!bus.tone_en && prev_tone) begin
                    check_output("tone_expected", int'(tone_q.size() > 0), 1);
                    if (tone_q.size() > 0) begin
                        tr = tone_q.pop_front();
                        check_output("tone_note", last_note, tr.note);
                        check_output("tone_octave", last_oct, tr.octave);
                        check_output("tone_offset", tone_start, tr.offset);
                        check_output("tone_len", tone_len, tr.len);
                    end
                end
                if (!bus.busy && prev_busy) begin
                    check_output("song_expected", int'(song_q.size() > 0), 1);
                    if (song_q.size() > 0) begin
                        s = song_q.pop_front();
                        check_output("busy_len", busy_cnt, s.busy_len);
                        check_output("song_done_pulses", done_cnt, s.dones);
                        check_output("final_play_addr", int'(bus.play_addr), s.addr);
                        check_output("final_octave", int'(bus.octave), s.octave);
                    end
                    busy_cnt = 0;
                    done_cnt = 0;
                end
                prev_busy = bus.busy;
                prev_tone = bus.tone_en;
            end
        end
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [11:0] end_mark;
        int stop_at;
        end_mark = make_entry(15, 0, 0, 0);
        bus.wr_en = 1'b0;
        bus.wr_addr = '0;
        bus.wr_data = '0;
        bus.start = 1'b0;
        bus.stop = 1'b0;
`ifdef MELODY_SEQ_LOOP_EN
        bus.loop = 1'b0;
`endif
        #23;
        check_output("reset_busy", int'(bus.busy), 0);
        check_output("reset_tone_en", int'(bus.tone_en), 0);
        check_output("reset_note", int'(bus.note), 0);
        check_output("reset_octave", int'(bus.octave), 0);
        check_output("reset_play_addr", int'(bus.play_addr), 0);
        check_output("reset_song_done", int'(bus.song_done), 0);
        @(negedge clk);
        rst_n = 1'b1;

        load_song(make_entry(3, 2, 0, 0), end_mark, end_mark, end_mark);
        apply_stimulus(0, 0, 0);

        load_song(make_entry(5, 1, 1, 1), make_entry(13, 7, 0, 0), end_mark, end_mark);
        apply_stimulus(0, 0, 0);

        load_song(make_entry(0, 0, 0, 0), make_entry(11, 5, 0, 1),
                  make_entry(4, 6, 0, 0), make_entry(7, 3, 0, 0));
        apply_stimulus(0, 0, 0);

        load_song(make_entry(2, 1, 0, 0), make_entry(7, 3, 0, 1), end_mark, end_mark);
        apply_stimulus(15, 0, 1);
        apply_stimulus(0, 0, 0);

        @(posedge clk);
        #1;
        bus.start = 1'b1;
        bus.stop = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        bus.stop = 1'b0;
        check_output("start_stop_idle", int'(bus.busy), 0);
        repeat (3) @(posedge clk);
        #1 check_output("start_stop_idle_hold", int'(bus.busy), 0);

        for (int i = 0; i < 10; i++) begin
            for (int a = 0; a < DEPTH; a++) begin
                write_entry(a, make_entry(($urandom_range(0, 5) == 0) ? 15 : int'($urandom_range(0, 14)),
                                          int'($urandom_range(0, 7)),
                                          $urandom_range(0, 3) == 0,
                                          int'($urandom_range(0, 2))));
            end
            stop_at = ($urandom_range(0, 2) == 0) ? int'($urandom_range(3, 70)) : 0;
            apply_stimulus(stop_at, 0, 0);
        end

`ifdef MELODY_SEQ_LOOP_EN
        load_song(make_entry(10, 1, 0, 0), end_mark, end_mark, end_mark);
        bus.loop = 1'b1;
        apply_stimulus(31, 1, 0);
        bus.loop = 1'b0;
`endif

        // Asynchronous reset in the middle of a long note.
        load_song(make_entry(5, 4, 0, 3), end_mark, end_mark, end_mark);
        @(posedge clk);
        #1 bus.start = 1'b1;
        @(posedge clk);
        #1 bus.start = 1'b0;
        repeat (6) @(posedge clk);
        #1 check_output("tone_before_reset", int'(bus.tone_en), 1);
        #2 rst_n = 1'b0;
        #1;
        check_output("async_busy", int'(bus.busy), 0);
        check_output("async_tone_en", int'(bus.tone_en), 0);
        check_output("async_note", int'(bus.note), 0);
        check_output("async_octave", int'(bus.octave), 0);
        check_output("async_play_addr", int'(bus.play_addr), 0);
        check_output("async_song_done", int'(bus.song_done), 0);
        @(negedge clk);
        rst_n = 1'b1;
        model_oct = 0;
        repeat (3) @(posedge clk);
        #1 check_output("idle_after_reset", int'(bus.busy), 0);

        load_song(make_entry(3, 2, 0, 0), end_mark, end_mark, end_mark);
        apply_stimulus(0, 0, 0);

        check_output("tone_queue_drained", tone_q.size(), 0);
        check_output("song_queue_drained", song_q.size(), 0);
        $display("[TB] %0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule

// File: doc/melody_sequencer.md
Name: melody_sequencer

Overview:
- Plays a stored song on the team's square-wave tone generator, replacing its free-running tone counter.
- Holds a small writable note memory and walks it on start. For each entry it presents note index (0-11, A..G#) and octave (0-5) plus a tone enable, timed by a beat counter with an articulation gap.
- Sits between the host/control logic and the tone generator.

Parameters:
- ADDR_W, 6, note memory address width; depth = 2**ADDR_W entries.
- BEAT_CYCLES, 6250000, clk cycles per beat (0.25 s at 25 MHz); must be >= 2.
- GAP_CYCLES, 625000, silent cycles at the end of each note; must satisfy 1 <= GAP_CYCLES < BEAT_CYCLES.

Ports:
- clk  in  1  system clock; all state on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- wr_en  in  1  note memory write strobe.
- wr_addr  in  ADDR_W  write address.
- wr_data  in  12  entry: [3:0] note, [6:4] octave, [7] rest, [11:8] duration in beats minus 1.
- start  in  1  single-cycle start request.
- stop  in  1  single-cycle abort request.
- busy  out  1  high in any state other than IDLE.
- tone_en  out  1  tone generator enable (speaker toggling allowed).
- note  out  4  note index to the generator, 0-11.
- octave  out  3  octave to the generator, 0-5.
- play_addr  out  ADDR_W  address of the current entry.
- song_done  out  1  one-cycle pulse at normal end of song.

Behaviour:
- Reset (async assert, sync deassert use): state=IDLE. busy=0, tone_en=0, note=0, octave=0, play_addr=0, song_done=0. Memory contents are not reset.
- Memory: synchronous write on wr_en only while busy=0; writes while busy=1 are dropped. Reads are synchronous with 1-cycle latency.
- End marker: note field = 15. Note values 12-14 play as rests. Octave field 6-7 is clamped to 5.
- States:
  - IDLE: start=1 and stop=0 -> FETCH, with play_addr=0.
  - FETCH: drive read address play_addr -> DECODE.
  - DECODE: latch entry.
    - End marker -> DONE.
    - Otherwise load note/octave and play counter = (dur+1)*BEAT_CYCLES - GAP_CYCLES -> PLAY.
  - PLAY: tone_en = ~rest; counter decrements; on counter reaching 1 -> GAP, loading GAP_CYCLES.
  - GAP: tone_en=0; note/octave hold; on counter reaching 1:
    - play_addr = 2**ADDR_W-1 -> DONE;
    - otherwise play_addr+1 and -> FETCH.
  - DONE: song_done=1 for this cycle only, tone_en=0 -> IDLE (see optional feature).
- Latency:
  - start sampled at edge N -> tone_en high after edge N+3.
  - Each note occupies exactly (dur+1)*BEAT_CYCLES + 2 cycles (PLAY + GAP + FETCH + DECODE).
- stop: from any busy state -> IDLE at the next edge. tone_en=0, no song_done, play_addr holds its last value.
- start and stop in the same cycle: stop wins. start while busy is ignored.
- Arithmetic: the play counter is 32 bits; the product is computed at full width with no overflow for the default parameters.
- note/octave remain at their last values when idle; the generator must qualify on tone_en.

Optional Feature:
- Macro: MELODY_SEQ_LOOP_EN.
- When defined, adds input loop (1 bit). In DONE with loop=1, song_done still pulses, then play_addr=0 -> FETCH instead of IDLE. busy stays 1 until stop.
- When undefined, the port is absent and DONE always -> IDLE.

Test Plan:
- Reset check: assert rst_n=0 mid-PLAY -> all outputs at reset values immediately, asynchronously; state=IDLE after release.
- Basic song (BEAT_CYCLES=8, GAP_CYCLES=2): mem[0]=note 3 oct 2 dur 0, mem[1]=note 15; start -> tone_en high 6 cycles after edge N+3 with note=3, octave=2; then low; song_done 1 pulse; busy drops. Total busy = 13 cycles.
- Rest and clamp: mem[0]={rest=1,dur=1}, mem[1]={note 13,oct 7,dur 0}, mem[2]=end -> tone_en stays 0 throughout. mem[1] presents octave=5. Note durations are 18 and 10 cycles.
- Address wrap (ADDR_W=2): four entries with no end marker -> after entry 3 GAP, DONE then IDLE; play_addr=3; no fetch from 0.
- Abort: stop during PLAY of entry 1 -> busy=0, tone_en=0 next edge, no song_done. A write during busy is dropped (readback after the song is unchanged). Simultaneous start+stop in IDLE -> stays IDLE.
- MELODY_SEQ_LOOP_EN with loop=1: two-note song -> song_done pulses each pass, FETCH of addr 0 follows DONE, busy stays high until stop.
